// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and round-robin helper for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 8;

  // Reference round-robin pick: first set bit searching ptr, ptr+1, ... mod num_req.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 num_req);
    logic [2:0] pick;
    logic [3:0] pos;
    pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < num_req) begin
        pos = {1'b0, ptr} + 4'(k);
        if (pos >= 4'(num_req)) pos = pos - 4'(num_req);
        if (valid[pos[2:0]]) pick = pos[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotate / find-first / unrotate priority picker
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any_valid,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  assign any_valid = |valid;

  always_comb begin
    rot = NUM_REQ'({valid, valid} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    // Offset back into absolute index space, modulo NUM_REQ (need not be a power of two).
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among producers
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_active,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [3:0]                    beat_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t             state, next_state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       next_ptr;
  logic                   pick_any;
  logic                   owner_valid;
  logic                   owner_last;
  logic [DATA_WIDTH-1:0]  owner_data;
  logic                   burst_done;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .any_valid (pick_any),
    .idx       (pick_idx)
  );

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDX_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign next_ptr     = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign grant_active = (state == GRANT);

  always_comb begin
    next_state   = state;
    req_ready    = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    burst_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) next_state = GRANT;
      end
      GRANT: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant_id == IDX_W'(i)) & ~fifo_full;
        end
        fifo_w_en    = owner_valid & ~fifo_full;
        fifo_data_in = owner_data;
        burst_done   = owner_last | (beat_cnt + 4'd1 == 4'(MAX_BURST));
        if (fifo_w_en && burst_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset must never leak a write or a handshake, even before the edge.
    if (rst) begin
      req_ready    = '0;
      fifo_w_en    = 1'b0;
      fifo_data_in = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && pick_any) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end else if (fifo_w_en) begin
        if (burst_done) begin
          rr_ptr   <= next_ptr;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for the FIFO write arbiter
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_data_in;
  logic        grant_active;
  logic [1:0]  grant_id;
  logic [3:0]  beat_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .beat_cnt     (beat_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Producer model: beats base+pc, packet of plen beats (0 = endless), valid from cycle en_cyc.
  int pc[4];
  int plen[4];
  int base[4];
  int en_cyc[4];
  int full_lo, full_hi, rst_cyc;

  int lg_wen[32];
  int lg_data[32];
  int lg_gact[32];
  int lg_gid[32];
  int lg_bc[32];
  int lg_rdy[32];
  int wr_q[$];

  task automatic expect_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      pc[i]     = 0;
      plen[i]   = 0;
      base[i]   = 0;
      en_cyc[i] = -1;
    end
    full_lo = 100;
    full_hi = -1;
    rst_cyc = -1;
    wr_q.delete();
  endtask

  task automatic do_reset();
    clear_model();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    logic act;
    rst       = (k == rst_cyc);
    fifo_full = (k >= full_lo && k <= full_hi);
    for (int i = 0; i < 4; i++) begin
      act = (en_cyc[i] >= 0) && (k >= en_cyc[i]) && (plen[i] == 0 || pc[i] < plen[i]);
      req_valid[i]          = act;
      req_data[i*8 +: 8]    = act ? 8'(base[i] + pc[i]) : 8'h00;
      req_last[i]           = act && (plen[i] != 0) && (pc[i] == plen[i] - 1);
    end
  endtask

  task automatic run_cycles(input int n);
    logic [3:0] acc;
    for (int k = 0; k < n; k++) begin
      drive(k);
      @(negedge clk);
      lg_wen[k]  = int'(fifo_w_en);
      lg_data[k] = int'(fifo_data_in);
      lg_gact[k] = int'(grant_active);
      lg_gid[k]  = int'(grant_id);
      lg_bc[k]   = int'(beat_cnt);
      lg_rdy[k]  = int'(req_ready);
      if (fifo_w_en) wr_q.push_back(int'(fifo_data_in));
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (acc[i]) pc[i]++;
    end
  endtask

  int exp_split[8] = '{'h10, 'h11, 'h12, 'h13, 'h30, 'h31, 'h14, 'h15};

  initial begin
    // Reset values
    do_reset();
    @(negedge clk);
    expect_eq("rst_wen",  int'(fifo_w_en), 0);
    expect_eq("rst_rdy",  int'(req_ready), 0);
    expect_eq("rst_gact", int'(grant_active), 0);
    expect_eq("rst_gid",  int'(grant_id), 0);
    expect_eq("rst_bc",   int'(beat_cnt), 0);
    expect_eq("rst_data", int'(fifo_data_in), 0);

    // Single producer, 3-beat packet
    do_reset();
    plen[0] = 3; base[0] = 'hA1; en_cyc[0] = 0;
    run_cycles(6);
    expect_eq("single_idle_gact", lg_gact[0], 0);
    expect_eq("single_idle_rdy",  lg_rdy[0], 0);
    expect_eq("single_b0_wen",    lg_wen[1], 1);
    expect_eq("single_b0_data",   lg_data[1], 'hA1);
    expect_eq("single_b1_data",   lg_data[2], 'hA2);
    expect_eq("single_b2_data",   lg_data[3], 'hA3);
    expect_eq("single_b2_rdy",    lg_rdy[3], 'b0001);
    expect_eq("single_rel_gact",  lg_gact[4], 0);
    expect_eq("single_rel_wen",   lg_wen[4], 0);
    expect_eq("single_count",     wr_q.size(), 3);

    // Round robin with all producers endlessly valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      base[i] = 'h40 + 'h10 * i; en_cyc[i] = 0;
    end
    run_cycles(22);
    for (int g = 0; g < 5; g++) begin
      int beats;
      expect_eq($sformatf("rr_gid_%0d", g), lg_gid[1 + 5*g], g % 4);
      if (g < 4) begin
        beats = 0;
        for (int c = 1 + 5*g; c < 5 + 5*g; c++) beats += lg_wen[c];
        expect_eq($sformatf("rr_beats_%0d", g), beats, 4);
        expect_eq($sformatf("rr_bubble_%0d", g), lg_wen[5 + 5*g], 0);
      end
    end
    expect_eq("rr_bc_last",  lg_bc[4], 3);
    expect_eq("rr_rdy_1hot", lg_rdy[6], 'b0010);
    expect_eq("rr_gid_held", lg_gid[5], 0);

    // FIFO full stall mid-burst
    do_reset();
    plen[2] = 4; base[2] = 'h20; en_cyc[2] = 0;
    full_lo = 2; full_hi = 4;
    run_cycles(9);
    for (int c = 2; c <= 4; c++) begin
      expect_eq($sformatf("stall_wen_%0d", c),  lg_wen[c], 0);
      expect_eq($sformatf("stall_rdy_%0d", c),  lg_rdy[c], 0);
      expect_eq($sformatf("stall_bc_%0d", c),   lg_bc[c], 1);
      expect_eq($sformatf("stall_gact_%0d", c), lg_gact[c], 1);
    end
    expect_eq("stall_resume", lg_data[5], 'h21);
    expect_eq("stall_count",  wr_q.size(), 4);
    for (int j = 0; j < 4 && j < wr_q.size(); j++)
      expect_eq($sformatf("stall_order_%0d", j), wr_q[j], 'h20 + j);
    expect_eq("stall_rel_gact", lg_gact[8], 0);

    // Burst split: producer 1 six beats, producer 3 two beats
    do_reset();
    plen[1] = 6; base[1] = 'h10; en_cyc[1] = 0;
    plen[3] = 2; base[3] = 'h30; en_cyc[3] = 0;
    run_cycles(12);
    expect_eq("split_count",  wr_q.size(), 8);
    for (int j = 0; j < 8 && j < wr_q.size(); j++)
      expect_eq($sformatf("split_order_%0d", j), wr_q[j], exp_split[j]);
    expect_eq("split_bubble", lg_wen[5], 0);
    expect_eq("split_gid3",   lg_gid[6], 3);

    // Reset mid-burst
    do_reset();
    plen[1] = 1; base[1] = 'h50; en_cyc[1] = 0;
    base[2] = 'h80; en_cyc[2] = 0;
    base[0] = 'h90; en_cyc[0] = 6;
    rst_cyc = 5;
    run_cycles(9);
    expect_eq("rstmid_bc_before", lg_bc[5], 2);
    expect_eq("rstmid_wen",       lg_wen[5], 0);
    expect_eq("rstmid_rdy",       lg_rdy[5], 0);
    expect_eq("rstmid_gact",      lg_gact[6], 0);
    expect_eq("rstmid_bc_after",  lg_bc[6], 0);
    expect_eq("rstmid_winner",    lg_gid[7], 0);
    expect_eq("rstmid_win_data",  lg_data[7], 'h90);

    // Pointer wrap from owner 3 with valids 1001
    do_reset();
    base[3] = 'h70; en_cyc[3] = 0;
    plen[0] = 1; base[0] = 'h60; en_cyc[0] = 1;
    run_cycles(10);
    expect_eq("wrap_first",  lg_gid[1], 3);
    expect_eq("wrap_bubble", lg_gact[5], 0);
    expect_eq("wrap_gid0",   lg_gid[6], 0);
    expect_eq("wrap_data0",  lg_data[6], 'h60);
    expect_eq("wrap_back3",  lg_gid[8], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
